// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;

  localparam int WB_XLEN      = 32;
  localparam int NUM_INT_REGS = 32;
  localparam int NUM_FP_REGS  = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_FPU = 2;

  typedef struct packed {
    logic [4:0]         rd;
    logic               fp;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot writeback grant. WB_ARB_RR_EN selects round-robin (with pointer);
// otherwise fixed priority, lowest index first.
module wb_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
`ifdef WB_ARB_RR_EN
  input  logic               clk,
  input  logic               rst,
`endif
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

`ifdef WB_ARB_RR_EN
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Search starts one past the last granted requester.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (grant_o == '0 && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        ptr_d        = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PW'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_o == '0 && valid_i[i]) grant_o[i] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter + register scoreboard in front of the register file's single
// write port. Define WB_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = WB_XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]      req_fp,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_fp,
  input  logic [4:0]              chk_rs1,
  input  logic [4:0]              chk_rs2,
  input  logic                    chk_rs1_fp,
  input  logic                    chk_rs2_fp,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    wr_en,
  output logic                    wr_float,
  output logic [4:0]              wr_reg,
  output logic [XLEN-1:0]         wr_data
);

  logic [NUM_REQ-1:0] grant_raw;
  wb_req_t            sel;

  logic               wr_en_q, wr_float_q;
  logic [4:0]         wr_reg_q;
  logic [XLEN-1:0]    wr_data_q;

  logic [NUM_INT_REGS-1:1] int_busy_q, int_busy_d;
  logic [NUM_FP_REGS-1:0]  fp_busy_q, fp_busy_d;
  logic [NUM_INT_REGS-1:0] int_view, int_next;

  wb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef WB_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .valid_i (req_valid),
    .grant_o (grant_raw)
  );

  // Reset forces the grant low even if a requester has not yet dropped valid.
  assign req_ready = grant_raw & {NUM_REQ{~rst}};

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel.rd   = req_rd[i*5 +: 5];
        sel.fp   = req_fp[i];
        sel.data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      wr_float_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
    end else if (|req_ready) begin
      // Integer x0 is consumed but never written.
      wr_en_q    <= sel.fp | (sel.rd != 5'd0);
      wr_float_q <= sel.fp;
      wr_reg_q   <= sel.rd;
      wr_data_q  <= sel.data;
    end else begin
      wr_en_q    <= 1'b0;
      wr_float_q <= 1'b0;
    end
  end

  assign int_view = {int_busy_q, 1'b0};

  // Clear first, then set, so a new producer wins a same-cycle collision.
  always_comb begin
    int_next  = int_view;
    fp_busy_d = fp_busy_q;
    if (wr_en_q) begin
      if (wr_float_q) fp_busy_d[wr_reg_q] = 1'b0;
      else            int_next[wr_reg_q]  = 1'b0;
    end
    if (issue_valid) begin
      if (issue_fp) fp_busy_d[issue_rd] = 1'b1;
      else          int_next[issue_rd]  = 1'b1;
    end
    int_busy_d = int_next[NUM_INT_REGS-1:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_busy_q <= '0;
      fp_busy_q  <= '0;
    end else begin
      int_busy_q <= int_busy_d;
      fp_busy_q  <= fp_busy_d;
    end
  end

  // A write landing this cycle is forwarded by the register file, so mask it.
  assign rs1_busy = (chk_rs1_fp ? fp_busy_q[chk_rs1] : int_view[chk_rs1]) &
                    ~(wr_en_q && (wr_float_q == chk_rs1_fp) && (wr_reg_q == chk_rs1));
  assign rs2_busy = (chk_rs2_fp ? fp_busy_q[chk_rs2] : int_view[chk_rs2]) &
                    ~(wr_en_q && (wr_float_q == chk_rs2_fp) && (wr_reg_q == chk_rs2));

  assign wr_en    = wr_en_q;
  assign wr_float = wr_float_q;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and scoreboard for the shared integer/float register file. It sits between the execution units (ALU, load/store unit, FPU) and the register file's single write port. Each cycle it grants at most one pending writeback and drives the register file's write-enable, float-select, address and data from a register stage. Alongside this it keeps per-register busy bits for both register banks, so decode can stall on operands whose producers have not yet written back.

## Interface
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = FPU)
- XLEN, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a writeback pending
- req_ready  out  NUM_REQ  one-hot grant; the handshake for requester i completes when req_valid[i] && req_ready[i]
- req_rd  in  NUM_REQ×5  destination register per requester
- req_fp  in  NUM_REQ  1 = float bank, 0 = integer bank
- req_data  in  NUM_REQ×XLEN  writeback data
- issue_valid  in  1  decode issued an instruction that will write a register
- issue_rd  in  5  destination of the issued instruction
- issue_fp  in  1  bank of the issued destination
- chk_rs1, chk_rs2  in  5 each  decode source operands
- chk_rs1_fp, chk_rs2_fp  in  1 each  bank of each source operand
- rs1_busy, rs2_busy  out  1 each  the source operand has an outstanding producer
- wr_en  out  1  register-file RegWrite
- wr_float  out  1  register-file FloatRegWrite
- wr_reg  out  5  register-file Write_reg
- wr_data  out  XLEN  register-file Write_data

## Operation
- Arbitration: req_ready is combinational from req_valid and the arbiter state; at most one bit is set, and it is set only if the matching req_valid is high.
- Requester obligations: once req_valid is asserted, it must stay high, with rd/fp/data stable, until granted. The arbiter never withdraws a grant while the requester is still valid.
- Write stage: on a grant, the write registers capture the request at the next edge.
  - Integer write: wr_en=1, wr_float=0.
  - Float write: wr_en=1, wr_float=1. The register file requires both bits for float writes.
  - Integer write to x0: the request is granted (consumed), but wr_en=0 and wr_float=0 are driven.
  - No grant: wr_en=0, wr_float=0; wr_reg and wr_data hold their previous values.
- Scoreboard storage: int_busy[31:1] and fp_busy[31:0]. Integer x0 is never busy.
  - Set: issue_valid sets busy[issue_rd] in the bank selected by issue_fp. Issue to integer x0 is ignored.
  - Clear: when the write stage presents wr_en=1, the matching bit clears at that same edge.
  - Collision: a set and a clear of the same register in the same cycle leaves the bit set, because the new producer wins.
- Operand busy check: rsN_busy = busy[chk_rsN] in the bank selected by chk_rsN_fp, masked to 0 when wr_en=1 and wr_reg/wr_float match that register and bank. The register file forwards Write_data in that cycle.
- Stray writebacks: a writeback to a register that is not busy is still written. No error is flagged.

## Timing
- Reset state: req_ready=0, wr_en=0, wr_float=0, wr_reg=0, wr_data=0, all busy bits 0, rs1_busy=0, rs2_busy=0, RR pointer = NUM_REQ-1 (so requester 0 has first priority).
- Latency: grant in cycle N; the register-file write appears in cycle N+1 and is committed at the end of N+1.
- Throughput: one writeback per cycle, sustained.
- Reset mid-operation: in-flight write-stage contents and all busy bits are discarded immediately. Requesters must drop valid during reset.

## Configuration
- Macro WB_ARB_RR_EN.
  - Defined: round-robin. The search starts at (last granted + 1) mod NUM_REQ. The pointer updates only on a grant.
  - Undefined: fixed priority, lowest index wins (ALU > LSU > FPU). The pointer register is removed.

## Structure
- Shared package `wb_pkg`: a typedef wb_req_t {rd[4:0], fp, data[XLEN-1:0]}, the constants NUM_INT_REGS=32 and NUM_FP_REGS=32, and the requester index constants.
- One sub-module `wb_rr_arbiter`: takes the valid vector and returns a one-hot grant. It contains the pointer under WB_ARB_RR_EN. The scoreboard stays inline.

## Test plan
- Single integer write: ALU requests rd=5, data=0xDEADBEEF.
  - Required: req_ready=001 the same cycle; next cycle wr_en=1, wr_float=0, wr_reg=5, wr_data=0xDEADBEEF.
- Float write path: FPU requests rd=3, fp=1, data=0x3F800000.
  - Required: wr_en=1 and wr_float=1 one cycle after the grant.
- x0 drop: ALU requests rd=0, fp=0.
  - Required: the grant is given; the next cycle shows wr_en=0.
- Three-way contention, all valid for 3 cycles:
  - With WB_ARB_RR_EN: grants 0, 1, 2 in that order.
  - Without it: grants 0, 1, 2 as each retires. Then with only requesters 1 and 0 re-asserted, 0 is granted first.
- Scoreboard: issue rd=7 int; next cycle, chk_rs1=7 gives rs1_busy=1 and chk f7 gives 0.
  - LSU writes rd=7 → in the write cycle rs1_busy=0 (bypass mask); the bit is clear afterwards.
- Collision and reset:
  - Issue rd=9 in the same cycle that the write stage retires rd=9 → the bit stays set.
  - Assert rst with pending busy bits → all busy bits and all outputs are 0 asynchronously.
